// File: rtl/xor_arb_pkg.sv
// Shared types and helpers for the XOR-bank arbiter: FSM states, default sizing,
// and the round-robin winner search.
package xor_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int XOR_ARB_N     = 4;
  localparam int XOR_ARB_WIDTH = 8;
  localparam int RR_MAX        = 16;

  // Requests are zero-extended to RR_MAX bits, so wrapping modulo 16 skips the
  // unused high bits and behaves exactly like wrapping modulo N.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [3:0]        ptr);
    logic [3:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + 4'(k);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/XOR2x1.sv
// Single 2-input XOR cell; one bit slice of the shared datapath bank.
module XOR2x1 (
  input  logic in0,
  input  logic in1,
  output logic out
);

  assign out = in0 ^ in1;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one XOR2x1 bank among N requesters; the response is valid
// two cycles after the grant cycle and is held in RESP until resp_ready, with no grants meanwhile.
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int N     = XOR_ARB_N,
  parameter int WIDTH = XOR_ARB_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [N*WIDTH-1:0]     req_a,
  input  logic [N*WIDTH-1:0]     req_b,
  output logic [N-1:0]           req_ready,
  output logic                   resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic [$clog2(N)-1:0]   resp_id,
  input  logic                   resp_ready,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam int IDW = $clog2(N);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [IDW-1:0]   win;
  logic [N-1:0]     grant;
  logic             accept;
  logic [WIDTH-1:0] win_a, win_b;
  logic [WIDTH-1:0] xor_out;

  always_comb begin
    win = IDW'(rr_pick(16'(req_valid), 4'(ptr_q)));
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IDW'(i)) begin
        win_a = req_a[i*WIDTH +: WIDTH];
        win_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is combinational so a requester sees ready in the same cycle it is chosen.
  always_comb begin
    grant = '0;
    if (state_q == IDLE && |req_valid) begin
      grant[win] = 1'b1;
    end
  end

  assign accept = |(req_valid & grant);

  genvar g;
  for (g = 0; g < WIDTH; g++) begin : g_xor_bank
    XOR2x1 u_xor (
      .in0 (opa_q[g]),
      .in1 (opb_q[g]),
      .out (xor_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = win_a;
          opb_d   = win_b;
          id_d    = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = xor_out;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == IDW'(N-1)) ? '0 : id_q + IDW'(1);
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = grant;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter: expected responses are queued at grant time
// and compared when the response appears; a second narrow instance sweeps the XOR truth table.
module tb_xor_share_arbiter;

  typedef struct {
    int id;
    int data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic        busy;
  logic [15:0] op_count;

  logic [3:0]  t_valid;
  logic [7:0]  t_a, t_b;
  logic [3:0]  t_ready;
  logic        t_rvalid;
  logic [1:0]  t_rdata;
  logic [1:0]  t_rid;
  logic        t_rready;
  logic        t_busy;
  logic [15:0] t_cnt;

  logic [7:0]  op_a [4];
  logic [7:0]  op_b [4];
  exp_t        sb [$];
  logic [1:0]  sb2 [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  xor_share_arbiter #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_id(resp_id), .resp_ready(resp_ready), .busy(busy), .op_count(op_count)
  );

  xor_share_arbiter #(.N(4), .WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(t_valid), .req_a(t_a), .req_b(t_b),
    .req_ready(t_ready), .resp_valid(t_rvalid), .resp_data(t_rdata),
    .resp_id(t_rid), .resp_ready(t_rready), .busy(t_busy), .op_count(t_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = op_a[i];
      req_b[i*8 +: 8] = op_b[i];
    end
  endtask

  task automatic check_resp();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_data", 32'(resp_data), e.data);
      chk("resp_id", 32'(resp_id), e.id);
    end
  endtask

  // One full operation with resp_ready high: grant cycle, EXEC cycle, RESP cycle.
  task automatic do_op(input logic [3:0] vld, input int win);
    logic [3:0] e;
    e = 4'(1 << win);
    @(negedge clk);
    req_valid = vld;
    #1;
    chk("grant", 32'(req_ready), 32'(e));
    sb.push_back('{win, int'(op_a[win] ^ op_b[win])});
    @(negedge clk);
    req_valid = vld & ~e;
    #1;
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_valid", 32'(resp_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    check_resp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    t_valid = '0; t_a = '0; t_b = '0; t_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 8'h13 + 8'(i * 8'h29);
      op_b[i] = 8'hC6 ^ 8'(i * 8'h17);
    end
    op_a[2] = 8'hA5;
    op_b[2] = 8'h0F;
    load_ops();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    rst = 1'b0;

    // Single request from requester 2
    do_op(4'b0100, 2);
    chk("single_data", 32'(resp_data), 32'h0000_00AA);
    chk("single_id", 32'(resp_id), 32'd2);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_count", 32'(op_count), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Fairness from a fresh pointer
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      do_op(4'b1111, g % 4);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("fair_count", 32'(op_count), 32'd5);

    // Backpressure: pointer is now 1, so requester 3 wins over 0
    @(negedge clk);
    req_valid = 4'b1001;
    resp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b1000);
    sb.push_back('{3, int'(op_a[3] ^ op_b[3])});
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("bp_exec_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_data_hold", 32'(resp_data), 32'(op_a[3] ^ op_b[3]));
      chk("bp_id_hold", 32'(resp_id), 32'd3);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("bp_ready_before_hs", 32'(req_ready), 32'd0);
    check_resp();
    // Pointer wrapped from 3 to 0
    do_op(4'b0001, 0);

    // Single active requester ignores the pointer, then wrap checks
    do_op(4'b1000, 3);
    do_op(4'b0010, 1);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("ptr_after_1", 32'(dut.ptr_q), 32'd2);
    do_op(4'b1010, 3);
    do_op(4'b1010, 1);

    // Reset while in EXEC aborts the operation
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("abort_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("abort_in_exec", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(op_count), 32'd0);
    chk("abort_ptr", 32'(dut.ptr_q), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end

    // Truth-table sweep on the 2-bit instance, requester 0
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        t_valid = 4'b0001;
        t_a = {6'b0, 2'(a)};
        t_b = {6'b0, 2'(b)};
        #1;
        chk("tt_grant", 32'(t_ready), 32'b0001);
        sb2.push_back(2'(a) ^ 2'(b));
        @(negedge clk);
        t_valid = '0;
        @(negedge clk);
        #1;
        chk("tt_valid", 32'(t_rvalid), 32'd1);
        chk("tt_id", 32'(t_rid), 32'd0);
        chk("tt_sb_nonempty", 32'(sb2.size() > 0), 32'd1);
        if (sb2.size() > 0) begin
          chk("tt_data", 32'(t_rdata), 32'(sb2.pop_front()));
        end
      end
    end
    @(negedge clk);
    #1;
    chk("tt_count", 32'(t_cnt), 32'd16);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb2_drained", 32'(sb2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
